// File: rtl/serial_cmd_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmd_tx_pkg
// Shared definitions for the serial command transmitter:
//   - 3-bit state encodings and the FSM state type
//   - line levels for idle/stop and the start bit
// -----------------------------------------------------------------------------
package serial_cmd_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    // The line rests high; a frame opens with a low start bit.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_cmd_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_cmd_tx_bit_timer
// Counts 0..BIT_CYCLES-1 while run is high and flags the last count, so the
// transmitter holds each serial bit for exactly BIT_CYCLES clocks.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset (clears the count)
//   run   - count enable; low clears the count back to 0
//   tick  - high during the last cycle of a bit period
// -----------------------------------------------------------------------------
module serial_cmd_tx_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!run || (count_reg == LAST_CNT)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Decoded from the registered count; consumed only by the FSM's
    // registered next-state logic.
    assign tick = run && (count_reg == LAST_CNT);

endmodule

// File: rtl/serial_cmd_tx.sv
// -----------------------------------------------------------------------------
// serial_cmd_tx
// Framed, LSB-first serial transmitter feeding the 2-bit shift-register
// command receivers. Frame: start(0), DATA_W data bits, optional even parity,
// stop(1); every bit held BIT_CYCLES clocks.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset; aborts a frame at once
//   data_in    - word to transmit, sampled on acceptance only
//   data_valid - requester has a word on data_in
//   data_ready - high only in IDLE (including the done cycle)
//   tx_line    - registered serial output, idles high
//   busy       - frame in progress
//   done       - one-cycle pulse, first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module serial_cmd_tx
    import serial_cmd_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              parity_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              timer_run;
    logic              tick;

    assign timer_run  = (state_reg != IDLE);
    assign shift_next = shift_reg >> 1;

    serial_cmd_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (timer_run),
        .tick  (tick)
    );

    // tx_line is loaded with the level of the state being entered, so it
    // changes on the same edge as the state and carries no input path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            idx_reg    <= '0;
            tx_line    <= IDLE_LEVEL;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_line    <= IDLE_LEVEL;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                    if (data_valid && data_ready) begin
                        shift_reg  <= data_in;
                        // Even parity: the XOR makes the total count of ones even.
                        parity_reg <= ^data_in;
                        state_reg  <= START;
                        tx_line    <= START_LEVEL;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_reg <= DATA;
                        idx_reg   <= '0;
                        tx_line   <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_next;
                        idx_reg   <= idx_reg + 1'b1;
                        if (idx_reg == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state_reg <= PARITY;
                                tx_line   <= parity_reg;
                            end else begin
                                state_reg <= STOP;
                                tx_line   <= IDLE_LEVEL;
                            end
                        end else begin
                            tx_line <= shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_reg <= STOP;
                        tx_line   <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_reg  <= IDLE;
                        tx_line    <= IDLE_LEVEL;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    tx_line    <= IDLE_LEVEL;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_cmd_tx
// Three transmitter instances: 0 = defaults, 1 = even parity, 2 = BIT_CYCLES=2
// looped back into a 2-bit shift-register receiver. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_cmd_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset      [3];
    logic [7:0] data_in    [3];
    logic       data_valid [3];
    logic       data_ready [3];
    logic       tx_line    [3];
    logic       busy       [3];
    logic       done       [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        serial_cmd_tx #(
            .DATA_W     (8),
            .BIT_CYCLES ((gi == 2) ? 2 : 4),
            .PARITY_EN  ((gi == 1) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .data_in    (data_in[gi]),
            .data_valid (data_valid[gi]),
            .data_ready (data_ready[gi]),
            .tx_line    (tx_line[gi]),
            .busy       (busy[gi]),
            .done       (done[gi])
        );
    end

    // Receiver model: two-stage sampler on instance 2, counting every level
    // change that reaches the second stage.
    logic [1:0] rx_sr   = 2'b11;
    logic       rx_prev = 1'b1;
    int         rx_edges = 0;
    always @(posedge clk) begin
        rx_sr   <= {rx_sr[0], tx_line[2]};
        rx_prev <= rx_sr[1];
        if (rx_sr[1] !== rx_prev) rx_edges <= rx_edges + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        check_eq($sformatf("%s inst%0d tx_line", tag, k), 32'(tx_line[k]), 32'd1);
        check_eq($sformatf("%s inst%0d data_ready", tag, k), 32'(data_ready[k]), 32'd1);
        check_eq($sformatf("%s inst%0d busy", tag, k), 32'(busy[k]), 32'd0);
    endtask

    // Starts at a falling edge with data_ready high; ends at the falling edge
    // of the done cycle. hold keeps data_valid high; poke disturbs the inputs
    // mid-frame.
    task automatic send_frame(input int k, input logic [7:0] w, input int bc, input int pe,
                              input bit hold, input bit poke);
        logic lv[$];
        int   fail0 = n_fail;
        int   cyc = 0;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(w[i]);
        if (pe != 0) lv.push_back(^w);
        lv.push_back(1'b1);

        data_in[k]    = w;
        data_valid[k] = 1'b1;
        @(negedge clk);
        if (!hold) data_valid[k] = 1'b0;
        foreach (lv[b]) begin
            for (int c = 0; c < bc; c++) begin
                check_eq($sformatf("inst%0d w%02h bit%0d cyc%0d tx_line", k, w, b, cyc),
                         32'(tx_line[k]), 32'(lv[b]));
                check_eq($sformatf("inst%0d w%02h cyc%0d busy", k, w, cyc), 32'(busy[k]), 32'd1);
                check_eq($sformatf("inst%0d w%02h cyc%0d done", k, w, cyc), 32'(done[k]), 32'd0);
                check_eq($sformatf("inst%0d w%02h cyc%0d data_ready", k, w, cyc),
                         32'(data_ready[k]), 32'd0);
                if (poke && cyc == 10) begin
                    data_in[k]    = ~w;
                    data_valid[k] = 1'b1;
                end
                if (poke && cyc == 12) data_valid[k] = 1'b0;
                cyc++;
                @(negedge clk);
            end
        end
        check_eq($sformatf("inst%0d w%02h done pulse", k, w), 32'(done[k]), 32'd1);
        check_idle(k, $sformatf("w%02h done cycle", w));
        $display("frame inst%0d word %02h: %0d bit cycles, %0d new failures",
                 k, w, cyc, n_fail - fail0);
    endtask

    initial begin
        int e0;
        for (int k = 0; k < 3; k++) begin
            reset[k]      = 1'b1;
            data_in[k]    = 8'h00;
            data_valid[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_idle(k, "after reset");
            check_eq($sformatf("after reset inst%0d done", k), 32'(done[k]), 32'd0);
        end
        $display("reset release: all instances idle");

        // Defaults: single frame, ignored mid-frame input, back-to-back.
        send_frame(0, 8'hA5, 4, 0, 1'b0, 1'b0);
        @(negedge clk);
        send_frame(0, 8'h3C, 4, 0, 1'b0, 1'b1);
        @(negedge clk);
        send_frame(0, 8'h0F, 4, 0, 1'b1, 1'b0);
        send_frame(0, 8'hF0, 4, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("after back-to-back done cleared", 32'(done[0]), 32'd0);

        // Even parity: 0xA5 -> 0, 0x01 -> 1.
        send_frame(1, 8'hA5, 4, 1, 1'b0, 1'b0);
        @(negedge clk);
        send_frame(1, 8'h01, 4, 1, 1'b0, 1'b0);

        // Loopback into the two-stage sampler with BIT_CYCLES=2.
        e0 = rx_edges;
        send_frame(2, 8'hA5, 2, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("loopback A5 edges", 32'(rx_edges - e0), 32'd8);
        $display("loopback word A5: %0d edges seen", rx_edges - e0);
        e0 = rx_edges;
        send_frame(2, 8'h55, 2, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("loopback 55 edges", 32'(rx_edges - e0), 32'd10);
        $display("loopback word 55: %0d edges seen", rx_edges - e0);

        // Reset abort in the DATA state.
        data_in[2]    = 8'h00;
        data_valid[2] = 1'b1;
        @(negedge clk);
        data_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort pre tx_line", 32'(tx_line[2]), 32'd0);
        check_eq("abort pre busy", 32'(busy[2]), 32'd1);
        #2;
        reset[2] = 1'b1;
        #1;
        check_idle(2, "async reset");
        check_eq("async reset done", 32'(done[2]), 32'd0);
        @(negedge clk);
        reset[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("post abort cyc%0d done", i), 32'(done[2]), 32'd0);
            check_eq($sformatf("post abort cyc%0d tx_line", i), 32'(tx_line[2]), 32'd1);
        end
        $display("reset abort: line released, no done pulse");
        send_frame(2, 8'h3C, 2, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
